// File: rtl/pyc_wrr_arb_if.sv
// Stream bundle for pyc_wrr_arb: N request streams in, one merged stream out.
// The slave modport is the arbiter's view; master is the surrounding logic.
interface pyc_wrr_arb_if #(
  parameter int WIDTH = 32,
  parameter int N     = 4
);
  localparam int SEL_W = $clog2(N <= 1 ? 2 : N);

  logic [N-1:0]            in_valid;
  logic [N-1:0]            in_ready;
  logic [N-1:0][WIDTH-1:0] in_data;
  logic [N-1:0]            in_last;
  logic                    out_valid;
  logic                    out_ready;
  logic [WIDTH-1:0]        out_data;
  logic                    out_last;
  logic [SEL_W-1:0]        out_sel;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_sel
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last, out_sel
  );
endinterface

// File: rtl/pyc_wrr_arb.sv
// Weighted, packet-aware round-robin arbiter: each input gets up to cfg_weight
// whole packets per turn; a multi-beat packet holds the grant until its last beat.
module pyc_wrr_arb #(
  parameter int WIDTH    = 32,
  parameter int N        = 4,
  parameter int WEIGHT_W = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  pyc_wrr_arb_if.slave                 bus,
  input  logic [N-1:0][WEIGHT_W-1:0]   cfg_weight,
  output logic                         locked
);
  localparam int SEL_W = $clog2(N <= 1 ? 2 : N);
  localparam int UW    = WEIGHT_W + 1;

  localparam logic [0:0] ST_ARB  = 1'b0;
  localparam logic [0:0] ST_LOCK = 1'b1;

  logic [0:0]          r_state;
  logic [SEL_W-1:0]    r_rr_ptr;
  logic [WEIGHT_W-1:0] r_cnt;
  logic [SEL_W-1:0]    r_owner;

  logic                w_arb_found;
  logic [SEL_W-1:0]    w_arb_idx;
  logic [SEL_W-1:0]    w_scan_idx;
  logic [SEL_W-1:0]    w_g;
  logic                w_valid;
  logic                w_xfer;
  logic [WEIGHT_W-1:0] w_wt;
  logic [UW-1:0]       w_eff;
  logic [UW-1:0]       w_used;
  logic [SEL_W-1:0]    w_next_ptr;

  // Rotating priority search starting at r_rr_ptr, wrapping modulo N.
  always_comb begin
    w_arb_found = 1'b0;
    w_arb_idx   = '0;
    w_scan_idx  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      w_scan_idx = SEL_W'((32'(r_rr_ptr) + k) % 32'(N));
      if (!w_arb_found && bus.in_valid[w_scan_idx]) begin
        w_arb_found = 1'b1;
        w_arb_idx   = w_scan_idx;
      end
    end
  end

  // While locked the owner alone may be granted, even if idle (bubble).
  always_comb begin
    if (r_state == ST_LOCK) begin
      w_g     = r_owner;
      w_valid = bus.in_valid[r_owner];
    end else begin
      w_g     = w_arb_idx;
      w_valid = w_arb_found;
    end
  end

  assign w_xfer = w_valid & bus.out_ready;

  always_comb begin
    bus.out_valid = w_valid;
    bus.out_data  = w_valid ? bus.in_data[w_g] : '0;
    bus.out_last  = w_valid ? bus.in_last[w_g] : 1'b0;
    bus.out_sel   = w_valid ? w_g : '0;
    bus.in_ready  = '0;
    if (w_xfer) begin
      bus.in_ready[w_g] = 1'b1;
    end
  end

  // One extra bit on used/eff keeps the weight compare from wrapping.
  assign w_wt       = cfg_weight[w_g];
  assign w_eff      = (w_wt == '0) ? UW'(1) : {1'b0, w_wt};
  assign w_used     = (w_g == r_rr_ptr) ? ({1'b0, r_cnt} + UW'(1)) : UW'(1);
  assign w_next_ptr = (w_g == SEL_W'(N - 1)) ? '0 : (w_g + SEL_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_ARB;
      r_rr_ptr <= '0;
      r_cnt    <= '0;
      r_owner  <= '0;
    end else if (w_xfer) begin
      if (!bus.out_last) begin
        r_state <= ST_LOCK;
        r_owner <= w_g;
      end else begin
        r_state <= ST_ARB;
        if (w_used >= w_eff) begin
          r_rr_ptr <= w_next_ptr;
          r_cnt    <= '0;
        end else begin
          r_rr_ptr <= w_g;
          r_cnt    <= w_used[WEIGHT_W-1:0];
        end
      end
    end
  end

  assign locked = (r_state == ST_LOCK);
endmodule

// File: tb/tb_pyc_wrr_arb.sv
// Directed vector bench for pyc_wrr_arb (N=4, WIDTH=32, WEIGHT_W=4): one vector
// per cycle with hand-computed grants, plus an asynchronous mid-packet reset.
module tb_pyc_wrr_arb;
  logic             clk;
  logic             rst_n;
  logic [3:0][3:0]  cfg_weight;
  logic             locked;

  pyc_wrr_arb_if #(.WIDTH(32), .N(4)) bus ();

  pyc_wrr_arb #(.WIDTH(32), .N(4), .WEIGHT_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .cfg_weight (cfg_weight),
    .locked     (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  v;
    logic [3:0]  l;
    logic [15:0] w;
    logic        ordy;
    logic        ev;
    logic [1:0]  es;
    logic        el;
    logic [3:0]  er;
    logic        elk;
  } vec_t;

  vec_t tv[$];
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic logic [31:0] data_of(input int i);
    return 32'hC0DE_0000 + 32'(i) * 32'h0000_0101;
  endfunction

  function automatic void add(input logic rst, input logic [3:0] v, input logic [3:0] l,
                              input logic [15:0] w, input logic ordy, input logic ev,
                              input logic [1:0] es, input logic el, input logic [3:0] er,
                              input logic elk);
    vec_t t;
    t.rst = rst; t.v = v; t.l = l; t.w = w; t.ordy = ordy;
    t.ev = ev; t.es = es; t.el = el; t.er = er; t.elk = elk;
    tv.push_back(t);
  endfunction

  task automatic chk(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s (step %0d): got %0h, expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic check_outputs(input int idx, input logic ev, input logic [1:0] es,
                               input logic el, input logic [3:0] er, input logic elk);
    chk("out_valid", idx, 64'(bus.out_valid), 64'(ev));
    chk("out_sel",   idx, 64'(bus.out_sel),   64'(ev ? es : 2'd0));
    chk("out_data",  idx, 64'(bus.out_data),  64'(ev ? data_of(int'(es)) : 32'd0));
    chk("out_last",  idx, 64'(bus.out_last),  64'(ev ? el : 1'b0));
    chk("in_ready",  idx, 64'(bus.in_ready),  64'(er));
    chk("locked",    idx, 64'(locked),        64'(elk));
  endtask

  localparam logic [15:0] W1 = 16'h1111;
  localparam logic [15:0] WB = 16'h1213;
  localparam logic [15:0] WC = 16'h1203;
  localparam logic [15:0] WF = 16'h1231;

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = '0;
    bus.in_last   = '0;
    bus.out_ready = 1'b0;
    cfg_weight    = W1;
    for (int i = 0; i < 4; i++) bus.in_data[i] = data_of(i);

    // Reset/idle, then plain round-robin with single-beat packets.
    add(1, 4'b0000, 4'b0000, W1, 1, 0, 0, 0, 4'b0000, 0);
    add(0, 4'b1111, 4'b1111, W1, 1, 1, 0, 1, 4'b0001, 0);
    add(0, 4'b1111, 4'b1111, W1, 1, 1, 1, 1, 4'b0010, 0);
    add(0, 4'b1111, 4'b1111, W1, 1, 1, 2, 1, 4'b0100, 0);
    add(0, 4'b1111, 4'b1111, W1, 1, 1, 3, 1, 4'b1000, 0);
    add(0, 4'b1111, 4'b1111, W1, 1, 1, 0, 1, 4'b0001, 0);
    add(0, 4'b1111, 4'b1111, W1, 1, 1, 1, 1, 4'b0010, 0);
    // Weights {3,1,2,1}.
    add(1, 4'b1111, 4'b1111, WB, 1, 1, 0, 1, 4'b0001, 0);
    add(0, 4'b1111, 4'b1111, WB, 1, 1, 0, 1, 4'b0001, 0);
    add(0, 4'b1111, 4'b1111, WB, 1, 1, 0, 1, 4'b0001, 0);
    add(0, 4'b1111, 4'b1111, WB, 1, 1, 1, 1, 4'b0010, 0);
    add(0, 4'b1111, 4'b1111, WB, 1, 1, 2, 1, 4'b0100, 0);
    add(0, 4'b1111, 4'b1111, WB, 1, 1, 2, 1, 4'b0100, 0);
    add(0, 4'b1111, 4'b1111, WB, 1, 1, 3, 1, 4'b1000, 0);
    add(0, 4'b1111, 4'b1111, WB, 1, 1, 0, 1, 4'b0001, 0);
    // Weight 0 on input 1 acts as 1.
    add(1, 4'b1111, 4'b1111, WC, 1, 1, 0, 1, 4'b0001, 0);
    add(0, 4'b1111, 4'b1111, WC, 1, 1, 0, 1, 4'b0001, 0);
    add(0, 4'b1111, 4'b1111, WC, 1, 1, 0, 1, 4'b0001, 0);
    add(0, 4'b1111, 4'b1111, WC, 1, 1, 1, 1, 4'b0010, 0);
    add(0, 4'b1111, 4'b1111, WC, 1, 1, 2, 1, 4'b0100, 0);
    add(0, 4'b1111, 4'b1111, WC, 1, 1, 2, 1, 4'b0100, 0);
    add(0, 4'b1111, 4'b1111, WC, 1, 1, 3, 1, 4'b1000, 0);
    // 4-beat packet on input 0 with a 2-cycle gap; input 1 waits.
    add(1, 4'b0011, 4'b0010, W1, 1, 1, 0, 0, 4'b0001, 0);
    add(0, 4'b0010, 4'b0010, W1, 1, 0, 0, 0, 4'b0000, 1);
    add(0, 4'b0010, 4'b0010, W1, 1, 0, 0, 0, 4'b0000, 1);
    add(0, 4'b0011, 4'b0010, W1, 1, 1, 0, 0, 4'b0001, 1);
    add(0, 4'b0011, 4'b0010, W1, 1, 1, 0, 0, 4'b0001, 1);
    add(0, 4'b0011, 4'b0011, W1, 1, 1, 0, 1, 4'b0001, 1);
    add(0, 4'b0011, 4'b0011, W1, 1, 1, 1, 1, 4'b0010, 0);
    add(0, 4'b0011, 4'b0011, W1, 1, 1, 0, 1, 4'b0001, 0);
    // Backpressure with inputs 2 and 3 valid.
    add(1, 4'b1100, 4'b1100, W1, 0, 1, 2, 1, 4'b0000, 0);
    add(0, 4'b1100, 4'b1100, W1, 0, 1, 2, 1, 4'b0000, 0);
    add(0, 4'b1100, 4'b1100, W1, 0, 1, 2, 1, 4'b0000, 0);
    add(0, 4'b1100, 4'b1100, W1, 0, 1, 2, 1, 4'b0000, 0);
    add(0, 4'b1100, 4'b1100, W1, 0, 1, 2, 1, 4'b0000, 0);
    add(0, 4'b1100, 4'b1100, W1, 1, 1, 2, 1, 4'b0100, 0);
    add(0, 4'b1100, 4'b1100, W1, 1, 1, 3, 1, 4'b1000, 0);
    add(0, 4'b1100, 4'b1100, W1, 1, 1, 2, 1, 4'b0100, 0);
    // Forfeit: input 1 (weight 3) drops after one packet; input 2 restarts at used=1.
    add(1, 4'b0010, 4'b0010, WF, 1, 1, 1, 1, 4'b0010, 0);
    add(0, 4'b0100, 4'b0100, WF, 1, 1, 2, 1, 4'b0100, 0);
    add(0, 4'b1110, 4'b1110, WF, 1, 1, 2, 1, 4'b0100, 0);
    add(0, 4'b1110, 4'b1110, WF, 1, 1, 3, 1, 4'b1000, 0);
    add(0, 4'b1110, 4'b1110, WF, 1, 1, 1, 1, 4'b0010, 0);

    for (int i = 0; i < tv.size(); i++) begin
      @(posedge clk); #1;
      bus.in_valid  = tv[i].v;
      bus.in_last   = tv[i].l;
      bus.out_ready = tv[i].ordy;
      cfg_weight    = tv[i].w;
      if (tv[i].rst) begin
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
      end
      @(negedge clk);
      check_outputs(i, tv[i].ev, tv[i].es, tv[i].el, tv[i].er, tv[i].elk);
    end

    // Asynchronous reset during beat 2 of input 3's packet.
    @(posedge clk); #1;
    rst_n = 1'b0; #1; rst_n = 1'b1;
    cfg_weight    = W1;
    bus.out_ready = 1'b1;
    bus.in_valid  = 4'b1000;
    bus.in_last   = 4'b0000;
    @(negedge clk);
    check_outputs(100, 1, 3, 0, 4'b1000, 0);
    @(posedge clk); #1;
    bus.in_valid = 4'b1001;
    @(negedge clk);
    check_outputs(101, 1, 3, 0, 4'b1000, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs(102, 1, 0, 0, 4'b0001, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.in_last = 4'b0001;
    @(negedge clk);
    check_outputs(103, 1, 0, 1, 4'b0001, 0);
    @(posedge clk); #1;
    bus.in_valid = 4'b0000;
    @(negedge clk);
    check_outputs(104, 0, 0, 0, 4'b0000, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/pyc_wrr_arb.md
# pyc_wrr_arb

Weighted, packet-aware round-robin ready/valid arbiter: merges N input streams onto one output, granting each input up to a run-time-configurable number of consecutive packets per turn. Once the first beat of a packet is accepted, the grant is held until that packet's last beat. It sits in front of shared datapaths (crossbar outputs, shared memory ports) where single-beat arbitration would interleave multi-beat packets. Selection is combinational (zero latency). Pointer, credit and lock state are registered.

## Interface
- `WIDTH`, default 32: data width per input.
- `N`, default 4: number of inputs, ≥1.
- `WEIGHT_W`, default 4: width of each per-input weight.
- `SEL_W` (localparam): `$clog2(N<=1 ? 2 : N)`.

Ports:
- `clk`  in  1: clock. All state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `in_valid`  in  N: per-input valid.
- `in_ready`  out  N: per-input ready. One-hot or zero.
- `in_data`  in  N×WIDTH: per-input data, packed `[N-1:0][WIDTH-1:0]`.
- `in_last`  in  N: per-input last-beat-of-packet flag.
- `cfg_weight`  in  N×WEIGHT_W: packets per turn for each input. A value of 0 is treated as 1.
- `out_valid`  out  1: output valid.
- `out_ready`  in  1: output ready.
- `out_data`  out  WIDTH: data of the granted input. Zero when `out_valid` is 0.
- `out_last`  out  1: `in_last` of the granted input. Zero when `out_valid` is 0.
- `out_sel`  out  SEL_W: granted index. Zero when `out_valid` is 0.
- `locked`  out  1: arbiter is in the LOCK state.

## Operation
- State registers:
  - `rr_ptr` (SEL_W): priority pointer.
  - `cnt` (WEIGHT_W): packets completed by `rr_ptr` in its current turn.
  - `owner` (SEL_W): input holding the lock.
  - `state` ∈ {ARB, LOCK}.
- Effective weight: `eff_w(i) = (cfg_weight[i]==0) ? 1 : cfg_weight[i]`. `cfg_weight` is sampled only at packet completion, so it may change at any time.
- Selection in ARB: the first `i` with `in_valid[i]`, searching `rr_ptr, rr_ptr+1, …` modulo N.
- Selection in LOCK: `g = owner`, and `out_valid = in_valid[owner]`. No other input may be granted, even while the owner is idle. This produces a bubble.
- Data path: `out_data`/`out_last`/`out_sel` follow `g`. `in_ready[g] = out_valid & out_ready`. All other `in_ready` bits are 0.
- A transfer occurs when `out_valid & out_ready`.
- Transfer with `out_last = 0`:
  - state ← LOCK, owner ← g.
  - `rr_ptr` and `cnt` are unchanged.
- Transfer with `out_last = 1` (packet completion):
  - state ← ARB.
  - `used = (g == rr_ptr) ? cnt + 1 : 1`.
  - If `used >= eff_w(g)`: `rr_ptr ← (g == N-1) ? 0 : g+1`, `cnt ← 0`.
  - Else: `rr_ptr ← g`, `cnt ← used`. The same input keeps priority for its next packet.
- Arithmetic: `used` is computed one bit wider than WEIGHT_W so the compare never wraps.
- Single-beat packets (`in_last = 1`) never enter LOCK.
- N = 1: `rr_ptr`, `owner` and `out_sel` are always 0. The lock and weight logic still run, with no observable effect on selection.

## Timing
- Reset values (`rst_n` low, asynchronous):
  - `rr_ptr = 0`, `cnt = 0`, `owner = 0`, `state = ARB`, `locked = 0`.
  - Outputs are combinational from these values and the inputs. With all `in_valid = 0`, `out_valid = 0`, `in_ready = 0`, `out_data = 0`, `out_sel = 0`.
- Reset mid-packet drops the lock immediately. The first cycle after release arbitrates from index 0.
- Latency:
  - `in_valid`/`in_data` → `out_*`: 0 cycles, combinational.
  - `out_ready` → `in_ready`: 0 cycles, combinational.
  - State changes are visible the cycle after the transfer.
- `out_valid` and `out_sel` never depend on `out_ready`.
- Simultaneous events:
  - A last beat accepted while other inputs are valid: the new owner is chosen next cycle from the updated `rr_ptr`.
  - A packet that is both first and last beat completes without locking.
- An input that drops valid during its turn forfeits the remainder. The next completing input g ≠ `rr_ptr` restarts the count at `used = 1`.

## Test plan
- **Reset and idle:** `rst_n = 0`, then release with all `in_valid = 0` → `out_valid = 0`, `in_ready = 0`, `out_sel = 0`, `locked = 0`. Assert `rst_n` low mid-cycle → state clears without a clock edge.
- **Plain round-robin:** N=4, all weights 1, all inputs valid, single-beat packets, `out_ready = 1` → `out_sel` sequence 0,1,2,3,0,1.
- **Weighting:** weights {3,1,2,1}, all valid, single-beat packets → `out_sel` sequence 0,0,0,1,2,2,3,0. A weight of 0 on input 1 behaves as 1.
- **Packet lock:** input 0 sends a 4-beat packet while input 1 is valid. Input 0 deasserts valid on beat 2 for 2 cycles → `out_valid = 0` during the gap, `locked = 1`, `in_ready[1] = 0` throughout. Grant moves to input 1 only after the beat with `out_last = 1` is accepted.
- **Backpressure:** `out_ready = 0` for 5 cycles with inputs 2 and 3 valid → `out_sel = 2` stable, `out_data` stable, `in_ready = 0`, `rr_ptr` unchanged.
- **Reset mid-packet and forfeit:**
  - Reset during beat 2 of input 3's packet → after release, input 0 is granted if valid.
  - Separately: with weight 3 on input 1, drop input 1 after its first packet → input 2 is granted and `cnt` restarts at 1.
